// File: rtl/fsm_3state.sv
// Three-state sequencer with externally supplied state encodings.
// Output y is the registered next state; a is the fed-back current state.
module fsm_3state (
  input  logic       clock,
  input  logic       reset,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic       en,
  input  logic [1:0] a,
  output logic [1:0] y
);

  logic [1:0] ns;

  // Ordered checks give c0 precedence when encodings collide.
  always_comb begin
    ns = a;
    if (a == c0 && i0)
      ns = c1;
    else if (a == c1 && i1)
      ns = c2;
    else if (a == c2 && i2)
      ns = c0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      y <= 2'd0;
    else if (en)
      y <= ns;
  end

endmodule

// File: tb/tb_fsm_3state.sv
// Directed bench for fsm_3state.
// Inputs change just after negedge; y is sampled at negedge.
module tb_fsm_3state;

  logic       clock;
  logic       reset;
  logic       i0, i1, i2;
  logic [1:0] c0, c1, c2;
  logic       en;
  logic [1:0] a;
  logic [1:0] y;
  logic       tie;
  logic [1:0] a_drv;

  int checks;
  int errors;

  assign a = tie ? y : a_drv;

  fsm_3state dut (
    .clock(clock),
    .reset(reset),
    .i0(i0),
    .i1(i1),
    .i2(i2),
    .c0(c0),
    .c1(c1),
    .c2(c2),
    .en(en),
    .a(a),
    .y(y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string      tag,
    input logic [1:0] got,
    input logic [1:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0] seq [11];
    seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2,
            2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    checks = 0;
    errors = 0;
    reset = 1'b1;
    tie = 1'b1;
    a_drv = 2'd0;
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    {i0, i1, i2} = 3'b111;
    en = 1'b1;

    // reset held across edges
    repeat (2) @(negedge clock);
    chk("reset_hold", y, 2'd0);
    @(negedge clock);
    chk("reset_hold2", y, 2'd0);
    reset = 1'b0;

    // free run
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("run_k%0d", k), y, seq[k]);
      @(negedge clock);
    end
    chk("run_k11", y, 2'd2);

    // stall in state 1
    @(negedge clock);
    chk("to_s0", y, 2'd0);
    @(negedge clock);
    chk("to_s1", y, 2'd1);
    i1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("stall%0d", k), y, 2'd1);
    end
    i1 = 1'b1;
    @(negedge clock);
    chk("stall_rel", y, 2'd2);

    // enable hold at state 2
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("en_hold%0d", k), y, 2'd2);
    end
    en = 1'b1;
    @(negedge clock);
    chk("en_rel", y, 2'd0);

    // async reset between edges
    @(negedge clock);
    chk("pre_rst1", y, 2'd1);
    @(negedge clock);
    chk("pre_rst2", y, 2'd2);
    #2 reset = 1'b1;
    #1 chk("async_rst", y, 2'd0);
    repeat (2) @(negedge clock);
    chk("rst_held", y, 2'd0);
    reset = 1'b0;
    #1 chk("rst_rel", y, 2'd0);
    @(negedge clock);
    chk("resume", y, 2'd1);

    // priority with c0 == c1
    tie = 1'b0;
    a_drv = 2'd1;
    c0 = 2'd1;
    c1 = 2'd1;
    c2 = 2'd3;
    @(negedge clock);
    chk("prio_c1", y, 2'd1);
    i0 = 1'b0;
    @(negedge clock);
    chk("prio_c2", y, 2'd3);
    i1 = 1'b0;
    @(negedge clock);
    chk("prio_stay", y, 2'd1);

    // c1 == c2 shadows c2 transition
    c0 = 2'd0;
    c1 = 2'd2;
    c2 = 2'd2;
    a_drv = 2'd2;
    i0 = 1'b1;
    i1 = 1'b1;
    i2 = 1'b1;
    @(negedge clock);
    chk("prio_c1c2", y, 2'd2);
    a_drv = 2'd0;
    @(negedge clock);
    chk("c0_to_c1", y, 2'd2);

    // illegal state 3 sticks
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    a_drv = 2'd3;
    @(negedge clock);
    chk("illegal_in", y, 2'd3);
    tie = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("illegal%0d", k), y, 2'd3);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
